// File: rtl/tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package tx_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} tx_state_t;

    localparam logic X_IDLE = 1'b0;

endpackage

// File: rtl/tick_gen.sv
// Bit-period counter: emits a one-cycle tick every DIV enabled cycles.
module tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CntLast = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: loads a WIDTH-bit pattern and shifts it out MSB first,
// holding each bit for DIV clk cycles, optionally repeating back-to-back.
module serial_pattern_tx
    import tx_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV   = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     load_valid_i,
    output logic                     load_ready_o,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     repeat_en_i,
    output logic                     x_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [$clog2(WIDTH)-1:0] bit_idx_o
);

    localparam int unsigned IW = $clog2(WIDTH);
    localparam logic [IW-1:0] IdxTop = IW'(WIDTH - 1);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             accept;
    logic             tick;
    logic             last_bit;

    assign accept   = load_valid_i && (state_q == IDLE);
    assign last_bit = tick && (idx_q == '0);

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (state_q == SHIFT),
        .clr_i   (accept),
        .tick_o  (tick)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (last_bit && !repeat_en_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_ready_o = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        x_o          = X_IDLE;
        unique case (state_q)
            IDLE:  load_ready_o = 1'b1;
            SHIFT: begin
                busy_o = 1'b1;
                x_o    = shift_q[WIDTH-1];
            end
            DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    // Final tick always reloads; on a non-repeated frame the reload just parks idx at the top.
    always_comb begin
        pat_d   = pat_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        if (accept) begin
            pat_d   = data_i;
            shift_d = data_i;
            idx_d   = IdxTop;
        end else if (state_q == SHIFT && tick) begin
            if (idx_q != '0) begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                idx_d   = idx_q - 1'b1;
            end else begin
                shift_d = pat_q;
                idx_d   = IdxTop;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pat_q   <= '0;
            shift_q <= '0;
            idx_q   <= IdxTop;
        end else begin
            pat_q   <= pat_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    assign bit_idx_o = idx_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Randomized self-checking bench for serial_pattern_tx (DIV=4 and DIV=1 instances).
module tb_serial_pattern_tx;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       lv;
    logic [3:0] data;
    logic       rep;

    logic       x4, busy4, done4, rdy4;
    logic [1:0] idx4;
    logic       x1, busy1, done1, rdy1;
    logic [1:0] idx1;

    logic       ox, obusy, odone, ordy;
    logic [1:0] oidx;

    int sel = 0;
    int total_cnt = 0;
    int bad_cnt = 0;

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(4), .DIV(4)) u_dut4 (
        .clk_i        (clk),
        .reset_i      (rst),
        .load_valid_i (lv),
        .load_ready_o (rdy4),
        .data_i       (data),
        .repeat_en_i  (rep),
        .x_o          (x4),
        .busy_o       (busy4),
        .done_o       (done4),
        .bit_idx_o    (idx4)
    );

    serial_pattern_tx #(.WIDTH(4), .DIV(1)) u_dut1 (
        .clk_i        (clk),
        .reset_i      (rst),
        .load_valid_i (lv),
        .load_ready_o (rdy1),
        .data_i       (data),
        .repeat_en_i  (rep),
        .x_o          (x1),
        .busy_o       (busy1),
        .done_o       (done1),
        .bit_idx_o    (idx1)
    );

    always_comb begin
        ox    = (sel != 0) ? x1 : x4;
        obusy = (sel != 0) ? busy1 : busy4;
        odone = (sel != 0) ? done1 : done4;
        ordy  = (sel != 0) ? rdy1 : rdy4;
        oidx  = (sel != 0) ? idx1 : idx4;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs t cycles after the accept edge, for a run of `frames` frames.
    function automatic void model(input int t, input logic [3:0] pat, input int frames,
                                  input int d, output logic ex, output logic eb,
                                  output logic ed, output logic er, output int ei);
        int wd;
        int total;
        wd    = W * d;
        total = frames * wd;
        ex = 1'b0; eb = 1'b0; ed = 1'b0; er = 1'b0; ei = W - 1;
        if (t < total) begin
            ei = W - 1 - ((t % wd) / d);
            ex = pat[ei];
            eb = 1'b1;
        end else if (t == total) begin
            ed = 1'b1;
        end else begin
            er = 1'b1;
        end
    endfunction

    task automatic check_outs(input string tag, input logic ex, input logic eb, input logic ed,
                              input logic er, input int ei);
        check_eq({tag, ".x"}, 32'(ox), 32'(ex));
        check_eq({tag, ".busy"}, 32'(obusy), 32'(eb));
        check_eq({tag, ".done"}, 32'(odone), 32'(ed));
        check_eq({tag, ".ready"}, 32'(ordy), 32'(er));
        check_eq({tag, ".idx"}, 32'(oidx), 32'(ei));
    endtask

    // Called at a negedge with the selected DUT idle; returns at a negedge with it idle again.
    task automatic do_frame(input string tag, input logic [3:0] pat, input int frames,
                            input int noise);
        int   d;
        int   wd;
        int   total;
        int   drop;
        logic ex, eb, ed, er;
        int   ei;
        d     = (sel != 0) ? 1 : 4;
        wd    = W * d;
        total = frames * wd;
        drop  = int'($urandom_range(wd - 1, 0));
        lv    = 1'b1;
        data  = pat;
        rep   = 1'($urandom_range(1, 0));
        @(negedge clk);
        for (int t = 0; t <= total + 1; t++) begin
            model(t, pat, frames, d, ex, eb, ed, er, ei);
            check_outs(tag, ex, eb, ed, er, ei);
            if (t < total) begin
                rep = ((t / wd) < frames - 1) ? 1'b1 : ((t % wd) < drop);
            end else begin
                rep = 1'($urandom_range(1, 0));
            end
            if (t <= total) begin
                case (noise)
                    1: begin lv = 1'($urandom_range(1, 0)); data = 4'($urandom); end
                    2: begin lv = 1'b1; data = 4'hf; end
                    default: lv = 1'b0;
                endcase
                @(negedge clk);
            end else begin
                lv = 1'b0;
            end
        end
    endtask

    task automatic reset_mid(input logic [3:0] pat);
        lv   = 1'b1;
        data = pat;
        rep  = 1'b0;
        @(negedge clk);
        lv = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("mid.idx", 32'(oidx), 32'd2);
        check_eq("mid.busy", 32'(obusy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_outs("rst_async", 1'b0, 1'b0, 1'b0, 1'b1, W - 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_outs("post_rst", 1'b0, 1'b0, 1'b0, 1'b1, W - 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        lv   = 1'b0;
        data = '0;
        rep  = 1'b0;
        #1;
        check_outs("rst_held", 1'b0, 1'b0, 1'b0, 1'b1, W - 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outs("rst_rel", 1'b0, 1'b0, 1'b0, 1'b1, W - 1);

        do_frame("f1011", 4'b1011, 1, 0);
        do_frame("f0110x3", 4'b0110, 3, 1);
        do_frame("f1001_ign", 4'b1001, 1, 2);
        reset_mid(4'b1001);
        do_frame("f1100", 4'b1100, 1, 0);
        for (int i = 0; i < 8; i++) begin
            do_frame("rnd4", 4'($urandom), int'($urandom_range(3, 1)), int'($urandom_range(2, 0)));
        end

        sel = 1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_frame("d1_1010", 4'b1010, 1, 0);
        for (int i = 0; i < 6; i++) begin
            do_frame("rnd1", 4'($urandom), int'($urandom_range(3, 1)), int'($urandom_range(2, 0)));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
